// File: rtl/adder4_pkg.sv
// Shared constants and helpers for the adder4 carry-lookahead datapath.
package adder4_pkg;

    localparam int unsigned GROUP_W = 4;

    function automatic logic is_legal_width(input int w);
        return (w > 0) && ((w % GROUP_W) == 0);
    endfunction

endpackage

// File: rtl/adder4_cla4_group.sv
// 4-bit carry-lookahead group: two-level carry expansion, also exposes the
// carry into bit 3 so the parent can derive signed overflow.
module cla4_group (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out,
    output logic       c3
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum-of-products of g, p and c_in.
    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_in);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c_in);

    assign s     = p ^ c[3:0];
    assign c_out = c[4];
    assign c3    = c[3];

endmodule

// File: rtl/adder4.sv
// Registered adder built from rippled 4-bit lookahead groups; one-cycle
// latency with carry-out, signed-overflow and zero flags.
module adder4
    import adder4_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             out_valid
);
    localparam int NG = WIDTH / GROUP_W;

    if (!is_legal_width(WIDTH)) begin : g_width_check
        $error("adder4: WIDTH must be a positive multiple of 4");
    end

    logic [NG:0]      carry;
    logic [NG-1:0]    c_msb;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             ovf_d;
    logic             zero_d;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             valid_q;

    assign carry[0] = cin;

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        cla4_group u_grp (
            .a     (a[gi*GROUP_W +: GROUP_W]),
            .b     (b[gi*GROUP_W +: GROUP_W]),
            .c_in  (carry[gi]),
            .s     (sum_d[gi*GROUP_W +: GROUP_W]),
            .c_out (carry[gi+1]),
            .c3    (c_msb[gi])
        );
    end

    assign cout_d = carry[NG];
    assign ovf_d  = c_msb[NG-1] ^ carry[NG];
    assign zero_d = ~|sum_d;

    // Flags hold across idle cycles; only out_valid tracks in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_adder4.sv
// Directed bench for adder4: reset, corner vectors, full sweep, hold and
// mid-stream reset.
module tb_adder4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
    logic       out_valid;

    int n_checks;
    int n_errors;

    adder4 #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed view of all outputs: {out_valid, ovf, zero, cout, sum}
    function automatic logic [7:0] outs();
        return {out_valid, ovf, zero, cout, sum};
    endfunction

    function automatic logic [7:0] pack(input logic v, input logic o, input logic z,
                                        input logic c, input logic [3:0] s);
        return {v, o, z, c, s};
    endfunction

    // Directed vectors: a, b, cin -> sum, cout, ovf, zero (hand-computed)
    localparam int NV = 6;
    logic [3:0] va   [NV] = '{4'd3, 4'd9, 4'd15, 4'd15, 4'd7, 4'd8};
    logic [3:0] vb   [NV] = '{4'd4, 4'd7, 4'd0,  4'd15, 4'd1, 4'd8};
    logic       vc   [NV] = '{1'b0, 1'b1, 1'b1,  1'b1,  1'b0, 1'b0};
    logic [3:0] vs   [NV] = '{4'd7, 4'd1, 4'd0,  4'd15, 4'd8, 4'd0};
    logic       vco  [NV] = '{1'b0, 1'b1, 1'b1,  1'b1,  1'b0, 1'b1};
    logic       vov  [NV] = '{1'b0, 1'b0, 1'b0,  1'b0,  1'b1, 1'b1};
    logic       vz   [NV] = '{1'b0, 1'b0, 1'b1,  1'b0,  1'b0, 1'b1};

    logic [7:0] held;
    logic [4:0] full;
    logic       exp_ovf;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;

        // Reset held with random toggling inputs
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a        = 4'($urandom_range(0, 15));
            b        = 4'($urandom_range(0, 15));
            cin      = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("reset_hold", 32'(outs()), 32'(pack(1'b0, 1'b0, 1'b1, 1'b0, 4'd0)));
        end

        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk); #1;
        check("reset_release_idle", 32'(outs()), 32'(pack(1'b0, 1'b0, 1'b1, 1'b0, 4'd0)));

        // Directed corner vectors
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            a = va[i]; b = vb[i]; cin = vc[i]; in_valid = 1'b1;
            @(posedge clk); #1;
            check($sformatf("directed_%0d", i), 32'(outs()),
                  32'(pack(1'b1, vov[i], vz[i], vco[i], vs[i])));
        end

        // Full sweep, one operand set per cycle, cin toggling each step
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            a = 4'(i >> 4); b = 4'(i); cin = 1'(i); in_valid = 1'b1;
            full    = 5'(a) + 5'(b) + 5'(cin);
            exp_ovf = (a[3] == b[3]) && (full[3] != a[3]);
            @(posedge clk); #1;
            check($sformatf("sweep_a%0d_b%0d_c%0d", a, b, cin), 32'(outs()),
                  32'(pack(1'b1, exp_ovf, full[3:0] == 4'd0, full[4], full[3:0])));
        end

        // Hold: last sweep result was 15+15+1 -> sum 15, cout 1
        held = pack(1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            a = 4'd1; b = 4'd1; cin = 1'b0;
            @(posedge clk); #1;
            check($sformatf("hold_%0d", i), 32'(outs()), 32'(held));
        end

        // Load a known result, then reset mid-cycle with new operands pending
        @(negedge clk);
        a = 4'd3; b = 4'd4; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        check("pre_reset_load", 32'(outs()), 32'(pack(1'b1, 1'b0, 1'b0, 1'b0, 4'd7)));
        @(negedge clk);
        a = 4'd5; b = 4'd6; cin = 1'b1; in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_clear", 32'(outs()), 32'(pack(1'b0, 1'b0, 1'b1, 1'b0, 4'd0)));
        @(posedge clk); #1;
        check("reset_discard", 32'(outs()), 32'(pack(1'b0, 1'b0, 1'b1, 1'b0, 4'd0)));
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        check("post_reset_idle", 32'(outs()), 32'(pack(1'b0, 1'b0, 1'b1, 1'b0, 4'd0)));

        // First result after reset
        @(negedge clk);
        a = 4'd9; b = 4'd7; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        check("post_reset_first", 32'(outs()), 32'(pack(1'b1, 1'b0, 1'b0, 1'b1, 4'd1)));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
